range_reduce_pipe: RTL and testbench
====================================

# range_reduce_pipe

Pipelined, parametrised argument-reduction stage for the sin/cos datapath, placed between operand unpack and the table/polynomial map-decode logic. It splits a normalised operand into integer and fractional parts and forwards the low integer bits as a quadrant code. The fraction is renormalised to a negative exponent, and zero results are forced to a clean 0/0 encoding. Data moves through three registered stages under a valid/ready handshake, so the block sustains one operand per cycle and honours downstream backpressure.

## Interface
- `EXP_WIDTH`, 8: signed (two's-complement) exponent width.
- `FRAC_WIDTH`, 32: mantissa width; MSB is the explicit leading one. Value = frac[FW-1].frac[FW-2:0] × 2^exp.
- `QBITS`, 2: number of low integer bits reported as the quadrant code (1..4).
- `TAG_WIDTH`, 4: opaque sideband carried with each operand.

Ports:
- `clk` in 1: clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_valid` in 1: operand valid.
- `o_ready` out 1: block accepts operand this cycle.
- `i_sign`, `i_exp`, `i_frac` in 1/EXP_WIDTH/FRAC_WIDTH: operand.
- `i_sincos` in 1: 1 = cos, 0 = sin.
- `i_tag` in TAG_WIDTH: sideband.
- `o_valid` out 1: result valid.
- `i_ready` in 1: downstream accepts result.
- `o_sign` out 1: always 0 (magnitude path).
- `o_exp`, `o_frac` out EXP_WIDTH/FRAC_WIDTH: reduced, normalised fraction.
- `o_quadrant` out QBITS: low integer bits of |x|.
- `o_sincos`, `o_tag` out 1/TAG_WIDTH: passthrough.
- `o_zero` out 1: reduced fraction is zero.
- `o_sign_flip` out 1: `~i_sincos & i_sign`; sin is odd, cos is even.

## Operation
- **S1, split:**
  - If exp ≥ 0, with e = exp: shifted = frac << (e+1), truncated to FW bits. If e ≥ FW−1, shifted = 0.
  - If exp ≥ 0, quadrant bit k = frac[FW−1−e+k] when k ≤ e and 0 ≤ FW−1−e+k ≤ FW−1; otherwise 0.
  - If exp < 0: bypass. shifted = frac, quadrant = 0, and the zero candidate is `~frac[FW-1]`.
- **S2, detect:**
  - Leading-zero count of the shifted fraction, ceil(log2 FW) bits.
  - zero = (shifted == 0) on the non-bypass path.
- **S3, normalise:**
  - Non-bypass: o_frac = shifted << lzd and o_exp = −(lzd+1), computed modulo 2^EXP_WIDTH.
  - Bypass: o_frac and o_exp are the original input values.
  - If zero: o_exp = 0 and o_frac = 0. The quadrant is still reported.
- Sign: o_sign = 0 and o_sign_flip = ~sincos & sign. Both are computed in S1 and piped.
- Each stage register holds a valid bit plus the full payload, including tag and sincos.

## Timing
- Latency: 3 cycles from an accepted input (i_valid & o_ready) to o_valid, when there is no stall.
- Throughput: 1 operand per cycle.
- A stage loads when its own valid is 0, or when the next stage loads this cycle. Stage 3 counts as loading when i_ready = 1.
- o_ready = !v1 | load into S2. This is a combinational path from i_ready. No skid buffer.
- o_valid = v3. Output payload is stable while o_valid & !i_ready.
- Bubbles collapse: an empty stage accepts data even while the output is stalled.
- Order is strictly preserved. No data is dropped or duplicated.
- Reset: every valid bit and every payload register clears to 0. Consequently, after reset:
  - o_valid = 0 and o_ready = 1.
  - o_exp, o_frac, o_quadrant, o_tag, o_zero, o_sign_flip and o_sincos are all 0.
- Reset asserted mid-stream discards all in-flight operands. No output may appear until a new operand is accepted after reset deasserts.

## Structure
- A shared package `fsincos_pkg` holds:
  - the default widths, `LZD_W = $clog2(FRAC_WIDTH)`;
  - the zero-encoding constants;
  - a payload struct covering sign_flip, sincos, tag, exp, frac, quadrant, zero and bypass.
- One sub-module, `lzd_param #(.W(FRAC_WIDTH))`: a parametrised leading-zero detector. Output is the count, width $clog2(W). An all-zero input returns W−1; callers qualify this case with the zero flag.
- Shifters are generic barrel shifts, not per-width case tables.

## Test plan
Defaults apply to all scenarios: EW = 8, FW = 32, QBITS = 2.
1. exp = 1, frac = 0xB0000000 (x = 2.75) → exp 0xFF, frac 0xC0000000, quadrant 2'b10, zero 0, 3 cycles later.
2. exp = 0xFE, frac = 0xC0000000 (x = 0.375) → bypass: exp 0xFE, frac 0xC0000000, quadrant 0, zero 0.
3. exp = 1, frac = 0xC0000000 (x = 3.0) → zero 1, exp 0, frac 0, quadrant 2'b11. Separately, exp = 40, any frac → zero 1, quadrant 0.
4. Sign flip: sign 1, sincos 0 → o_sign_flip 1. Sign 1, sincos 1 → 0. o_sign is always 0.
5. Backpressure: 6 back-to-back operands with tags 0..5, and i_ready low for cycles 4–6.
   - o_ready drops once all three stages are full.
   - Tags emerge as 0..5 in order, with no loss or duplication.
   - Output is held stable while stalled.
6. Reset: assert rst with 2 operands in flight → o_valid = 0 immediately and all outputs are 0. After release, o_ready = 1 and nothing emerges until a new input is accepted.

Source files
------------

// File: rtl/range_reduce_pipe_pkg.sv
// Shared widths, zero encoding and payload layout for the sin/cos
// argument-reduction datapath.
package fsincos_pkg;

    localparam int EXP_WIDTH_DEF  = 8;
    localparam int FRAC_WIDTH_DEF = 32;
    localparam int QBITS_DEF      = 2;
    localparam int TAG_WIDTH_DEF  = 4;
    localparam int LZD_W          = $clog2(FRAC_WIDTH_DEF);

    localparam logic [EXP_WIDTH_DEF-1:0]  ZERO_EXP  = '0;
    localparam logic [FRAC_WIDTH_DEF-1:0] ZERO_FRAC = '0;

    typedef struct packed {
        logic                      sign_flip;
        logic                      sincos;
        logic [TAG_WIDTH_DEF-1:0]  tag;
        logic [EXP_WIDTH_DEF-1:0]  exp;
        logic [FRAC_WIDTH_DEF-1:0] frac;
        logic [QBITS_DEF-1:0]      quadrant;
        logic                      zero;
        logic                      bypass;
    } payload_t;

endpackage

// File: rtl/range_reduce_pipe_lzd.sv
// Parametrised leading-zero detector; all-zero input yields W-1,
// so callers must qualify that case with their own zero flag.
module lzd_param #(
    parameter int W  = 32,
    parameter int CW = $clog2(W)
) (
    input  logic [W-1:0]  in_i,
    output logic [CW-1:0] cnt_o
);

    always_comb begin
        cnt_o = CW'(W - 1);
        // Highest set bit is visited last and wins.
        for (int i = 0; i < W; i++) begin
            if (in_i[i]) begin
                cnt_o = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/range_reduce_pipe.sv
// Three-stage sin/cos argument reduction: split integer/fraction,
// detect leading zeros, renormalise. Valid/ready with backpressure.
module range_reduce_pipe
    import fsincos_pkg::*;
#(
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int QBITS      = QBITS_DEF,
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sign,
    input  logic [EXP_WIDTH-1:0]  i_exp,
    input  logic [FRAC_WIDTH-1:0] i_frac,
    input  logic                  i_sincos,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sign,
    output logic [EXP_WIDTH-1:0]  o_exp,
    output logic [FRAC_WIDTH-1:0] o_frac,
    output logic [QBITS-1:0]      o_quadrant,
    output logic                  o_sincos,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic                  o_zero,
    output logic                  o_sign_flip
);

    localparam int LW = $clog2(FRAC_WIDTH);

    typedef struct packed {
        logic                  sign_flip;
        logic                  sincos;
        logic [TAG_WIDTH-1:0]  tag;
        logic [EXP_WIDTH-1:0]  exp;
        logic [FRAC_WIDTH-1:0] frac;
        logic [QBITS-1:0]      quadrant;
        logic                  zero;
        logic                  bypass;
    } stage_t;

    stage_t s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    logic v1_q, v2_q, v3_q;
    logic ld1, ld2, ld3;
    logic [LW-1:0] lzd_d, lzd_q;
    logic [EXP_WIDTH:0] sh_amt;
    int idx;
    logic unused_bypass;

    assign ld3     = ~v3_q | i_ready;
    assign ld2     = ~v2_q | ld3;
    assign ld1     = ~v1_q | ld2;
    assign o_ready = ld1;

    always_comb begin
        idx              = 0;
        sh_amt           = {1'b0, i_exp} + (EXP_WIDTH + 1)'(1);
        s1_d.sign_flip   = i_sign & ~i_sincos;
        s1_d.sincos      = i_sincos;
        s1_d.tag         = i_tag;
        s1_d.exp         = i_exp;
        s1_d.bypass      = i_exp[EXP_WIDTH-1];
        s1_d.quadrant    = '0;
        s1_d.frac        = i_frac;
        s1_d.zero        = ~i_frac[FRAC_WIDTH-1];
        if (!s1_d.bypass) begin
            // Shift counts >= FRAC_WIDTH clear the fraction entirely.
            s1_d.frac = i_frac << sh_amt;
            s1_d.zero = 1'b0;
            for (int k = 0; k < QBITS; k++) begin
                idx = FRAC_WIDTH - 1 - int'(i_exp) + k;
                if (k <= int'(i_exp) && idx >= 0 && idx < FRAC_WIDTH) begin
                    s1_d.quadrant[k] = i_frac[idx[LW-1:0]];
                end
            end
        end
    end

    lzd_param #(.W(FRAC_WIDTH)) u_lzd (
        .in_i  (s1_q.frac),
        .cnt_o (lzd_d)
    );

    always_comb begin
        s2_d = s1_q;
        if (!s1_q.bypass) begin
            s2_d.zero = (s1_q.frac == '0);
        end
    end

    always_comb begin
        s3_d = s2_q;
        if (!s2_q.bypass) begin
            s3_d.frac = s2_q.frac << lzd_q;
            // -(lzd+1) in two's complement is simply ~lzd.
            s3_d.exp  = ~EXP_WIDTH'(lzd_q);
        end
        if (s2_q.zero) begin
            s3_d.exp  = EXP_WIDTH'(ZERO_EXP);
            s3_d.frac = FRAC_WIDTH'(ZERO_FRAC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            lzd_q <= '0;
        end else begin
            if (ld1) begin
                v1_q <= i_valid;
                if (i_valid) s1_q <= s1_d;
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s2_q  <= s2_d;
                    lzd_q <= lzd_d;
                end
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) s3_q <= s3_d;
            end
        end
    end

    assign o_valid       = v3_q;
    assign o_sign        = 1'b0;
    assign o_exp         = s3_q.exp;
    assign o_frac        = s3_q.frac;
    assign o_quadrant    = s3_q.quadrant;
    assign o_sincos      = s3_q.sincos;
    assign o_tag         = s3_q.tag;
    assign o_zero        = s3_q.zero;
    assign o_sign_flip   = s3_q.sign_flip;
    assign unused_bypass = s3_q.bypass;

endmodule

// File: tb/tb_range_reduce_pipe.sv
// Randomised and directed bench for range_reduce_pipe against an
// arithmetic reference model and an in-order scoreboard.
module tb_range_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, o_ready, i_sign, i_sincos, i_ready;
    logic [7:0]  i_exp;
    logic [31:0] i_frac;
    logic [3:0]  i_tag;
    logic        o_valid, o_sign, o_sincos, o_zero, o_sign_flip;
    logic [7:0]  o_exp;
    logic [31:0] o_frac;
    logic [1:0]  o_quadrant;
    logic [3:0]  o_tag;

    always #5 clk = ~clk;

    range_reduce_pipe dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_frac(i_frac),
        .i_sincos(i_sincos), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_sign(o_sign), .o_exp(o_exp), .o_frac(o_frac),
        .o_quadrant(o_quadrant), .o_sincos(o_sincos), .o_tag(o_tag),
        .o_zero(o_zero), .o_sign_flip(o_sign_flip)
    );

    typedef struct {
        logic [7:0]  exp;
        logic [31:0] frac;
        logic [1:0]  q;
        logic        z;
        logic        sf;
        logic        sc;
        logic [3:0]  tag;
    } res_t;

    res_t sb[$];
    int checks = 0;
    int errors = 0;
    logic last_acc, last_ov, last_ordy, last_del;
    logic [3:0] last_tag;
    int delivered = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value = frac * 2^(exp-31); split into integer and fractional parts.
    function automatic res_t model(input logic s, input logic [7:0] e,
                                   input logic [31:0] f, input logic sc,
                                   input logic [3:0] t);
        res_t r;
        int ev, p, sh;
        logic [63:0] fb, ip;
        r.sf = s & ~sc;
        r.sc = sc;
        r.tag = t;
        r.q = 2'd0;
        r.z = 1'b0;
        r.exp = 8'd0;
        r.frac = 32'd0;
        if ($signed(e) < 0) begin
            if (f[31]) begin
                r.exp = e;
                r.frac = f;
            end else begin
                r.z = 1'b1;
            end
        end else begin
            ev = int'(e);
            if (ev >= 31) begin
                sh = ev - 31;
                ip = 64'(f) << sh;
                r.q = (sh >= 2) ? 2'd0 : ip[1:0];
                r.z = 1'b1;
            end else begin
                ip = 64'(f) >> (31 - ev);
                fb = 64'(f) & ((64'd1 << (31 - ev)) - 64'd1);
                r.q = ip[1:0];
                if (fb == 64'd0) begin
                    r.z = 1'b1;
                end else begin
                    p = 0;
                    for (int i = 0; i < 64; i++) if (fb[i]) p = i;
                    r.exp = 8'(p - (31 - ev));
                    r.frac = 32'(fb << (31 - p));
                end
            end
        end
        return r;
    endfunction

    task automatic step(input logic v, input logic s, input logic [7:0] e,
                        input logic [31:0] f, input logic sc,
                        input logic [3:0] t, input logic rdy);
        res_t r;
        i_valid = v; i_sign = s; i_exp = e; i_frac = f;
        i_sincos = sc; i_tag = t; i_ready = rdy;
        #1;
        last_acc = i_valid & o_ready;
        last_ov = o_valid;
        last_ordy = o_ready;
        last_del = o_valid & i_ready;
        last_tag = o_tag;
        if (o_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                r = sb[0];
                check("exp", o_exp, r.exp);
                check("frac", o_frac, r.frac);
                check("quadrant", o_quadrant, r.q);
                check("zero", o_zero, r.z);
                check("sign_flip", o_sign_flip, r.sf);
                check("sincos", o_sincos, r.sc);
                check("tag", o_tag, r.tag);
                check("sign", o_sign, 0);
                if (i_ready) begin
                    void'(sb.pop_front());
                    delivered++;
                end
            end
        end
        if (last_acc) sb.push_back(model(s, e, f, sc, t));
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 4'd0, rdy);
    endtask

    task automatic directed(input string nm, input logic s, input logic [7:0] e,
                            input logic [31:0] f, input logic sc,
                            input logic [7:0] xe, input logic [31:0] xf,
                            input logic [1:0] xq, input logic xz,
                            input logic xsf);
        int lat;
        step(1'b1, s, e, f, sc, 4'hA, 1'b0);
        check({nm, "_accept"}, last_acc, 1);
        lat = 0;
        do begin
            idle(1'b0);
            lat++;
        end while (!last_ov && lat < 10);
        check({nm, "_latency"}, lat, 3);
        check({nm, "_exp"}, o_exp, xe);
        check({nm, "_frac"}, o_frac, xf);
        check({nm, "_quad"}, o_quadrant, xq);
        check({nm, "_zero"}, o_zero, xz);
        check({nm, "_sflip"}, o_sign_flip, xsf);
        idle(1'b1);
        idle(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, nt;
        logic saw_low;
        logic [7:0] e;
        logic [31:0] f;
        rst = 1'b1;
        i_valid = 0; i_sign = 0; i_exp = 0; i_frac = 0;
        i_sincos = 0; i_tag = 0; i_ready = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_exp", o_exp, 0);
        check("rst_frac", o_frac, 0);
        check("rst_tag", o_tag, 0);
        rst = 1'b0;

        directed("t1", 0, 8'd1, 32'hB000_0000, 0, 8'hFF, 32'hC000_0000, 2'b10, 0, 0);
        directed("t2", 0, 8'hFE, 32'hC000_0000, 0, 8'hFE, 32'hC000_0000, 2'b00, 0, 0);
        directed("t3", 0, 8'd1, 32'hC000_0000, 0, 8'h00, 32'h0, 2'b11, 1, 0);
        directed("t3b", 0, 8'd40, $urandom, 1, 8'h00, 32'h0, 2'b00, 1, 0);
        directed("t4a", 1, 8'd1, 32'hB000_0000, 0, 8'hFF, 32'hC000_0000, 2'b10, 0, 1);
        directed("t4b", 1, 8'd1, 32'hB000_0000, 1, 8'hFF, 32'hC000_0000, 2'b10, 0, 0);

        // Backpressure: six operands, output stalled on cycles 4..6.
        t = 0; nt = 0; saw_low = 0; delivered = 0;
        for (c = 1; c <= 40 && (t < 6 || sb.size() > 0); c++) begin
            step(t < 6, 0, 8'd1, 32'hB000_0000 + (t << 8), 0, t[3:0],
                 !(c >= 4 && c <= 6));
            if (last_acc) t++;
            if (!last_ordy) saw_low = 1;
            if (last_del) begin
                check("bp_order", last_tag, nt);
                nt++;
            end
        end
        check("bp_count", delivered, 6);
        check("bp_ready_drop", saw_low, 1);
        check("bp_drain", sb.size(), 0);

        // Reset with two operands in flight.
        step(1, 0, 8'd1, 32'hB000_0000, 1, 4'h7, 1);
        step(1, 1, 8'd2, 32'hE000_0000, 0, 4'h8, 1);
        i_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_out", {o_exp, o_frac, o_quadrant, o_tag,
                              o_zero, o_sign_flip, o_sincos}, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", o_ready, 1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check("post_rst_quiet", last_ov, 0);
        end
        directed("t6", 0, 8'd1, 32'hB000_0000, 0, 8'hFF, 32'hC000_0000, 2'b10, 0, 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: e = 8'($urandom_range(0, 33));
                1: e = 8'($urandom_range(0, 127));
                2: e = 8'(-$urandom_range(1, 128));
                default: e = 8'($urandom_range(0, 3));
            endcase
            f = $urandom;
            if ($urandom_range(0, 7) != 0) f[31] = 1'b1;
            step($urandom_range(0, 3) != 0, 1'($urandom), e, f,
                 1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1);
        check("final_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
